// File: rtl/vc32_bus_target.sv
// vc32_bus_target: responder for the vc32 8-bit multiplexed bus, backed by a 2^AW byte array.
// Defining VC32_BUS_TARGET_TIMER_EN maps a 16-bit reload timer at 0x3FFFFE/0x3FFFFF.
module vc32_bus_target #(
    parameter int AW = 12,
    parameter int PA = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_ad,
    input  logic       latch_hi,
    input  logic       latch_lo,
    input  logic       write,
    input  logic       ind,
    output logic [7:0] rdata,
    output logic       interrupt,
    output logic       proto_err
);
`ifdef VC32_BUS_TARGET_TIMER_EN
    localparam int HW = PA;
`else
    localparam int HW = AW;
`endif
    // Only address bits that can affect behaviour are stored; the rest alias away.
    localparam logic [HW-1:1] MID_M = (HW-1)'({8'hff, 7'h00});
    localparam logic [HW-1:1] LO_M  = (HW-1)'(7'h7f);

    typedef enum logic [1:0] {IDLE, GOT_HI, GOT_MID, DATA} state_t;

    state_t          state_q;
    logic [HW-1:1]   addr_q;
    logic            err_q;
    logic [HW-1:1]   hi_a, mid_a, lo_a, rd_a;
    logic [1:0]      s;
    logic            lo_ph, rd_en, wr_en, s_err, w_err, tmr_wr;
    logic [AW-1:0]   idx;
    logic [7:0]      mem [0:(1<<AW)-1];

    assign s         = {latch_hi, latch_lo};
    assign lo_ph     = (state_q == GOT_MID) && (s == 2'b01);
    assign rd_en     = lo_ph || (state_q == DATA);
    assign wr_en     = write && (state_q == DATA) && (s == 2'b00);
    assign w_err     = write && !wr_en;
    assign s_err     = (state_q == GOT_HI) ? (s != 2'b11) : (state_q == GOT_MID) ? (s != 2'b01) : s[0];
    assign hi_a      = (HW-1)'({bus_ad[PA-17:0], 15'h0000});
    assign mid_a     = (addr_q & ~MID_M) | (HW-1)'({bus_ad, 7'h00});
    assign lo_a      = (addr_q & ~LO_M) | (HW-1)'(bus_ad[7:1]);
    assign rd_a      = lo_ph ? lo_a : addr_q;
    assign idx       = AW'({rd_a, ind});
    assign proto_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (s_err || w_err) err_q <= 1'b1;
            // A high phase always (re)starts a transaction, even out of sequence.
            if (s == 2'b10) begin
                state_q <= GOT_HI;
                addr_q  <= hi_a;
            end else if (s_err) begin
                state_q <= IDLE;
            end else if (state_q == GOT_HI) begin
                state_q <= GOT_MID;
                addr_q  <= mid_a;
            end else if (state_q == GOT_MID) begin
                state_q <= DATA;
                addr_q  <= lo_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !tmr_wr) mem[idx] <= bus_ad;
    end

`ifdef VC32_BUS_TARGET_TIMER_EN
    logic [15:0] reload_q, cnt_q;
    logic        irq_q, tmr_hit, tmr_rd, tick;

    assign tmr_hit   = &rd_a;
    assign tmr_wr    = wr_en && tmr_hit;
    assign tmr_rd    = rd_en && !write && tmr_hit && !ind;
    assign tick      = !(tmr_wr && ind) && (reload_q != 16'h0000) && (cnt_q == 16'd1);
    assign rdata     = !rd_en ? 8'h00 : tmr_hit ? (ind ? reload_q[15:8] : reload_q[7:0]) : mem[idx];
    assign interrupt = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (tmr_wr && !ind) reload_q[7:0] <= bus_ad;
            if (tmr_wr && ind) begin
                reload_q[15:8] <= bus_ad;
                cnt_q          <= {bus_ad, reload_q[7:0]};
            end else if (reload_q != 16'h0000) begin
                cnt_q <= (cnt_q <= 16'd1) ? reload_q : cnt_q - 16'd1;
            end
            // A new expiry wins over a clearing read in the same cycle.
            irq_q <= tick || (irq_q && !tmr_rd);
        end
    end
`else
    assign tmr_wr    = 1'b0;
    assign rdata     = rd_en ? mem[idx] : 8'h00;
    assign interrupt = 1'b0;
`endif
endmodule
